fpu_addsub_param: RTL and testbench
===================================

// Module: fpu_addsub_param
// PURPOSE
// - Parametrised floating-point add/subtract unit for the custom sign|exp|mantissa format (no inf/NaN encodings).
// - Successor to the fixed 32-bit (6-bit exp, 25-bit mantissa) adder; widths are generic.
// - Adds an explicit start/done handshake, an add/sub op select and round-to-nearest-even with guard/round/sticky.
// - Sits between operand registers and the result bus; one operation in flight, fixed latency.
// PARAMETERS
// - EXP_W  6   exponent field width; bias = 2**(EXP_W-1)-1 (31 at default)
// - MAN_W  25  stored mantissa width (hidden 1 not stored); word width W = 1+EXP_W+MAN_W
// PORTS
// - clock100KHz  in   1      single clock; all state on rising edge
// - reset        in   1      asynchronous, active-low reset
// - start_in     in   1      request; sampled only while busy_out=0
// - op_sub_in    in   1      0: A+B, 1: A-B; latched with operands
// - op_A_in      in   W      operand A {sign, exp, mantissa}
// - op_B_in      in   W      operand B
// - busy_out     out  1      high from accepting edge until done cycle ends
// - done_out     out  1      one-cycle pulse; data_out/status_out valid from this cycle
// - data_out     out  W      result; held until the next done_out
// - status_out   out  4      one-hot: 0001 EXACT, 0010 INEXACT, 0100 OVERFLOW, 1000 UNDERFLOW
// BEHAVIOUR
// - Reset: state IDLE; data_out=0, status_out=0001, done_out=0, busy_out=0. Reset mid-op aborts with no done_out.
// - FSM: IDLE->ALIGN->ADD->NORM->ROUND->PACK->IDLE, one cycle per state.
// - Latency: start accepted at edge 0; done_out=1 after edge 5; next start accepted at edge 6 earliest.
// - start_in while busy_out=1 is ignored; operands are latched at acceptance, so later input changes have no effect.
// - Operand with exp field 0 is zero (flush-to-zero); the mantissa is ignored.
// - A-B: B sign inverted at latch.
// - ALIGN: hidden bit prepended; mantissas extended by 3 bits (G,R,S).
//   - Smaller-exponent operand right-shifted by diff; shifted-out bits OR into S.
//   - diff >= MAN_W+3: the whole operand goes to S.
// - ADD, equal signs: magnitude sum with 1 carry bit; result sign = common sign.
// - ADD, differing signs: larger minus smaller; sign of the larger.
// - ADD, exact cancellation: +0, except (-0)+(-0) = -0.
// - NORM: carry -> shift right 1 (LSB ORed into S), exp+1.
//   - Otherwise a single-cycle leading-zero count left-shifts to restore the hidden 1 and subtracts the count from exp.
// - ROUND: RNE; increment if G & (R|S|lsb). Mantissa carry-out -> mantissa=0, exp+1.
//   - INEXACT whenever G|R|S = 1.
// - Exponent arithmetic is EXP_W+2 bits signed; no wrap-around.
// - Overflow: exp > 2**EXP_W-1; status 0100; data per CONFIGURATION.
// - Underflow: exp < 1 with nonzero magnitude; data = signed zero; status 1000.
// - Status priority: OVERFLOW > UNDERFLOW > INEXACT > EXACT; exactly one bit set.
// CONFIGURATION
// - FPU_SATURATE_EN defined: overflow returns {sign, all-ones exp, all-ones mantissa}.
// - FPU_SATURATE_EN undefined: overflow returns all-zero data_out. Status is 0100 in both cases.
// TESTING (default parameters)
// - Add: 0x3E000000 (1.0) + 0x3E000000 -> 0x40000000, status 0001, done exactly 5 edges after start.
// - Add: 0x3F000000 (1.5) + 0x3F000000 -> 0x41000000 (3.0), 0001.
// - Sub: op_sub=1, 1.0 - 1.0 -> 0x00000000, 0001.
// - Tie to even: 0x3E000000 + 0x0A000000 (2^-26) -> 0x3E000000, status 0010.
// - Overflow: 0x7FFFFFFF + 0x7FFFFFFF -> 0x00000000 (0x7FFFFFFF with FPU_SATURATE_EN), status 0100.
// - Underflow: 0x03000000 - 0x02000000 (op_sub=1) -> 0x00000000, status 1000.
// - Busy start: start pulse at edge 2 of an op is ignored, only one done.
// - Mid-op reset: reset low at edge 3 -> outputs at reset values, no done.

Source files
------------

// File: rtl/fpu_addsub_param.sv
`timescale 1ns/1ps
// Parametrised add/subtract for the sign|exp|mantissa format (no inf/NaN), RNE rounding,
// fixed six-state pipeline FSM. Define FPU_SATURATE_EN to saturate on overflow instead of zeroing.
module fpu_addsub_param #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         start_in,
  input  logic         op_sub_in,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);
  localparam int MW   = MAN_W + 4;   // hidden + mantissa + G,R,S
  localparam int EW   = EXP_W + 2;
  localparam int LZ_W = $clog2(MW);

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;
  localparam logic [3:0] ST_OVF     = 4'b0100;
  localparam logic [3:0] ST_UNF     = 4'b1000;

  localparam logic [MW-1:0]        MAG_ONES  = '1;
  localparam logic [31:0]          SHIFT_ALL = 32'(MAN_W + 3);
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK} state_t;
  state_t state, state_nxt;

  logic                 sign_a, sign_b;
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MW-1:0]        mag_a, mag_b;

  logic                 w_sign, w_sign_small, w_nonzero, w_inexact;
  logic signed [EW-1:0] w_exp;
  logic [MW-1:0]        w_big, w_small, w_norm;
  logic [MW:0]          w_sum;
  logic [MAN_W-1:0]     w_man;

  logic                 al_a_big, al_s_big, al_s_small, al_sticky;
  logic [EXP_W-1:0]     al_e_big, al_e_small;
  logic [MW-1:0]        al_x_big, al_x_small, al_small;
  logic [31:0]          al_diff;

  logic [MW:0]          add_sum;
  logic                 add_sign;

  logic [LZ_W-1:0]      lz;
  logic                 lz_found;
  logic [MW-1:0]        lz_probe;
  logic signed [EW-1:0] lz_ext, norm_exp;
  logic [MW-1:0]        norm_mag;

  logic                 rnd_inc, rnd_carry, rnd_inexact;
  logic [MAN_W-1:0]     rnd_man;
  logic signed [EW-1:0] rnd_exp;

  logic [W-1:0]         pack_data;
  logic [3:0]           pack_status;

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_in) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_PACK;
      S_PACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Busy stretches over the done cycle; a start in that cycle still lands on the IDLE edge.
  assign busy_out = (state != S_IDLE) || done_out;

  // Order by {exp, mantissa} so the larger magnitude is always the minuend.
  always_comb begin
    al_a_big   = {exp_a, mag_a} >= {exp_b, mag_b};
    al_e_big   = al_a_big ? exp_a  : exp_b;
    al_e_small = al_a_big ? exp_b  : exp_a;
    al_x_big   = al_a_big ? mag_a  : mag_b;
    al_x_small = al_a_big ? mag_b  : mag_a;
    al_s_big   = al_a_big ? sign_a : sign_b;
    al_s_small = al_a_big ? sign_b : sign_a;
    al_diff    = 32'(al_e_big) - 32'(al_e_small);
    al_sticky  = 1'b0;
    if (al_diff >= SHIFT_ALL) begin
      al_sticky = |al_x_small;
      al_small  = '0;
    end else begin
      al_sticky = |(al_x_small & ~(MAG_ONES << al_diff));
      al_small  = al_x_small >> al_diff;
    end
    al_small = al_small | {{(MW-1){1'b0}}, al_sticky};
  end

  always_comb begin
    add_sign = w_sign;
    if (w_sign == w_sign_small) begin
      add_sum = {1'b0, w_big} + {1'b0, w_small};
    end else begin
      add_sum = {1'b0, w_big} - {1'b0, w_small};
      if (add_sum == '0) add_sign = 1'b0;
    end
  end

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    lz_probe = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      lz_probe = w_sum[MW-1:0] << i;
      if (!lz_found && lz_probe[MW-1]) begin
        lz       = LZ_W'(i);
        lz_found = 1'b1;
      end
    end
    lz_ext = EW'(lz);
    if (w_sum[MW]) begin
      norm_mag = w_sum[MW:1] | {{(MW-1){1'b0}}, w_sum[0]};
      norm_exp = w_exp + EXP_ONE;
    end else begin
      norm_mag = w_sum[MW-1:0] << lz;
      norm_exp = w_exp - lz_ext;
    end
  end

  always_comb begin
    rnd_inc              = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    rnd_inexact          = |w_norm[2:0];
    {rnd_carry, rnd_man} = {1'b0, w_norm[MW-2:3]} + {{MAN_W{1'b0}}, rnd_inc};
    rnd_exp              = w_exp;
    if (rnd_carry) begin
      rnd_man = '0;
      rnd_exp = w_exp + EXP_ONE;
    end
  end

  always_comb begin
    pack_data   = '0;
    pack_status = ST_EXACT;
    if (!w_nonzero) begin
      pack_data = {w_sign, {(W-1){1'b0}}};
    end else if (w_exp > EXP_MAX) begin
      pack_status = ST_OVF;
`ifdef FPU_SATURATE_EN
      pack_data   = {w_sign, {(W-1){1'b1}}};
`else
      pack_data   = '0;
`endif
    end else if (w_exp < EXP_ONE) begin
      pack_status = ST_UNF;
      pack_data   = {w_sign, {(W-1){1'b0}}};
    end else begin
      pack_data   = {w_sign, w_exp[EXP_W-1:0], w_man};
      pack_status = w_inexact ? ST_INEXACT : ST_EXACT;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      exp_a        <= '0;
      exp_b        <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      w_sign       <= 1'b0;
      w_sign_small <= 1'b0;
      w_nonzero    <= 1'b0;
      w_inexact    <= 1'b0;
      w_exp        <= '0;
      w_big        <= '0;
      w_small      <= '0;
      w_norm       <= '0;
      w_sum        <= '0;
      w_man        <= '0;
      data_out     <= '0;
      status_out   <= ST_EXACT;
      done_out     <= 1'b0;
    end else begin
      done_out <= (state == S_PACK);
      unique case (state)
        S_IDLE: if (start_in) begin
          sign_a <= op_A_in[W-1];
          sign_b <= op_B_in[W-1] ^ op_sub_in;
          exp_a  <= op_A_in[W-2:MAN_W];
          exp_b  <= op_B_in[W-2:MAN_W];
          mag_a  <= (op_A_in[W-2:MAN_W] == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0], 3'b000};
          mag_b  <= (op_B_in[W-2:MAN_W] == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0], 3'b000};
        end
        S_ALIGN: begin
          w_sign       <= al_s_big;
          w_sign_small <= al_s_small;
          w_exp        <= EW'(al_e_big);
          w_big        <= al_x_big;
          w_small      <= al_small;
        end
        S_ADD: begin
          w_sum  <= add_sum;
          w_sign <= add_sign;
        end
        S_NORM: begin
          w_norm <= norm_mag;
          w_exp  <= norm_exp;
        end
        S_ROUND: begin
          w_man     <= rnd_man;
          w_exp     <= rnd_exp;
          w_inexact <= rnd_inexact;
          w_nonzero <= w_norm[MW-1];
        end
        S_PACK: begin
          data_out   <= pack_data;
          status_out <= pack_status;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_addsub_param.sv
`timescale 1ns/1ps
// Scoreboard bench for fpu_addsub_param: exact big-integer reference model, directed corners,
// randomized operands, busy-start and mid-operation reset.
module tb_fpu_addsub_param;
  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] data;
  logic [3:0]   status;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   status;
    int           t0;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  fpu_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock100KHz(clk),
    .reset      (rst_n),
    .start_in   (start),
    .op_sub_in  (op_sub),
    .op_A_in    (op_a),
    .op_B_in    (op_b),
    .busy_out   (busy),
    .done_out   (done),
    .data_out   (data),
    .status_out (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Exact sum on an integer grid of 2^(1-bias-MAN_W), then round-to-nearest-even to MAN_W+1 bits.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                    output logic [W-1:0] d, output logic [3:0] st);
    logic [127:0] ma, mb, mag, q, rem, half, tmp;
    logic         sa, sb, sr, inexact;
    int           ea, eb, p, e, sh;
    sa = a[W-1];
    sb = b[W-1] ^ sub;
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    ma = '0;
    mb = '0;
    if (ea != 0) ma = ((128'(1) << MAN_W) | 128'(a[MAN_W-1:0])) << (ea - 1);
    if (eb != 0) mb = ((128'(1) << MAN_W) | 128'(b[MAN_W-1:0])) << (eb - 1);
    if (sa == sb)     begin mag = ma + mb; sr = sa;   end
    else if (ma > mb) begin mag = ma - mb; sr = sa;   end
    else if (mb > ma) begin mag = mb - ma; sr = sb;   end
    else              begin mag = '0;      sr = 1'b0; end
    if (mag == '0) begin
      d  = {sr, {(W-1){1'b0}}};
      st = 4'b0001;
    end else begin
      p = 0;
      for (int i = 0; i < 128; i++) begin
        tmp = mag >> i;
        if (tmp[0]) p = i;
      end
      e = p - MAN_W + 1;
      inexact = 1'b0;
      if (p > MAN_W) begin
        sh   = p - MAN_W;
        q    = mag >> sh;
        rem  = mag & ((128'(1) << sh) - 128'(1));
        half = 128'(1) << (sh - 1);
        inexact = (rem != '0);
        if (rem > half || (rem == half && q[0])) q = q + 128'(1);
        if (q[MAN_W+1]) begin
          q = q >> 1;
          e = e + 1;
        end
      end else begin
        q = mag << (MAN_W - p);
      end
      if (e > EMAX) begin
        st = 4'b0100;
`ifdef FPU_SATURATE_EN
        d  = {sr, {(W-1){1'b1}}};
`else
        d  = '0;
`endif
      end else if (e < 1) begin
        st = 4'b1000;
        d  = {sr, {(W-1){1'b0}}};
      end else begin
        st = inexact ? 4'b0010 : 4'b0001;
        d  = {sr, EXP_W'(e), q[MAN_W-1:0]};
      end
    end
  endfunction

  // mode 0: untracked, 1: reference model, 2: given constants. Entered and left at a negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int mode, input logic [W-1:0] cd, input logic [3:0] cst);
    int           guard;
    logic [W-1:0] d;
    logic [3:0]   st;
    guard = 0;
    while (busy && !done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", busy, guard);
    end
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_sub = sub;
    @(posedge clk);
    #1;
    if (mode == 1) begin
      ref_model(a, b, sub, d, st);
      sb_q.push_back('{data: d, status: st, t0: cycle});
    end else if (mode == 2) begin
      sb_q.push_back('{data: cd, status: cst, t0: cycle});
    end
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    op_sub = 1'($urandom);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done_out=1 data=0x%08h, required no completion", data);
      end else begin
        e = sb_q.pop_front();
        check("data",    data,          e.data);
        check("status",  32'(status),   32'(e.status));
        check("latency", 32'(cycle),    32'(e.t0 + 5));
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] a, b;
    logic         sub;
    int           ea, eb, guard;
    logic [W-1:0] ovf_data;
`ifdef FPU_SATURATE_EN
    ovf_data = 32'h7FFFFFFF;
`else
    ovf_data = 32'h00000000;
`endif
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",   data,         32'h0);
    check("reset_status", 32'(status),  32'h1);
    check("reset_done",   32'(done),    32'h0);
    check("reset_busy",   32'(busy),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h3E000000, 32'h3E000000, 1'b0, 2, 32'h40000000, 4'b0001);
    issue(32'h3F000000, 32'h3F000000, 1'b0, 2, 32'h41000000, 4'b0001);
    issue(32'h3E000000, 32'h3E000000, 1'b1, 2, 32'h00000000, 4'b0001);
    issue(32'h3E000000, 32'h0A000000, 1'b0, 2, 32'h3E000000, 4'b0010);
    issue(32'h3E000000, 32'h0A000001, 1'b0, 2, 32'h3E000001, 4'b0010);
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 2, ovf_data,     4'b0100);
    issue(32'h03000000, 32'h02000000, 1'b1, 2, 32'h00000000, 4'b1000);
    issue(32'h80000000, 32'h80000000, 1'b0, 2, 32'h80000000, 4'b0001);
    issue(32'h80000000, 32'h00000000, 1'b1, 2, 32'h80000000, 4'b0001);
    issue(32'h01FFFFFF, 32'h3E000000, 1'b0, 2, 32'h3E000000, 4'b0001);

    // A start sampled at edge 2 of an operation must be ignored.
    issue(32'h3E000000, 32'h3F000000, 1'b0, 1, '0, '0);
    @(negedge clk);
    check("busy_during_op", 32'(busy), 32'h1);
    start = 1'b1;
    op_a  = 32'h5A5A5A5A;
    op_b  = 32'h12345678;
    @(negedge clk);
    start = 1'b0;

    for (int n = 0; n < 300; n++) begin
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom);
      ea  = int'(a[W-2:MAN_W]);
      case ($urandom_range(0, 3))
        1: begin
          eb = ea + int'($urandom_range(0, 6)) - 3;
          if (eb < 1) eb = 1;
          if (eb > EMAX) eb = EMAX;
          b[W-2:MAN_W] = EXP_W'(eb);
        end
        2: begin
          b      = a;
          b[3:0] = 4'($urandom);
          sub    = 1'b1;
        end
        3: begin
          if ($urandom_range(0, 1) == 0) a[W-2:MAN_W] = '0;
          else                           b[W-2:MAN_W] = '0;
        end
        default: ;
      endcase
      issue(a, b, sub, 1, '0, '0);
    end

    // Reset at edge 3 of an operation aborts it with no completion.
    issue(32'h3E000000, 32'h3E000000, 1'b0, 0, '0, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_data",   data,        32'h0);
    check("midreset_status", 32'(status), 32'h1);
    check("midreset_done",   32'(done),   32'h0);
    check("midreset_busy",   32'(busy),   32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(32'h3F000000, 32'h3E000000, 1'b1, 2, 32'h3C000000, 4'b0001);

    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
